// File: rtl/phy_mdio_ctrl.sv
// IEEE 802.3 clause-22 MDIO management master: one read or write frame per accepted command.
// MDC is divided from sys_clk; the MDIO pad tristate is controlled through mdio_o/mdio_oe.
module phy_mdio_ctrl #(
  parameter int unsigned CLK_DIV     = 10,
  parameter int unsigned PREAMBLE_EN = 1
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] RISE_CNT = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, GAP} state_t;

  state_t           state;
  state_t           nxt_state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [4:0]       nxt_bit_cnt;
  logic             wr_q;
  logic             ta_bit;
  logic [31:0]      tx_sr;
  logic [14:0]      rx_sr;
  logic [31:0]      frame;
  logic             rise;
  logic             bit_end;

  // ST, OP, PHYAD, REGAD, write turnaround and data; on reads only the first 14 bits go out
  assign frame   = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                    2'b10, cmd_wdata};
  assign rise    = (div_cnt == RISE_CNT);
  assign bit_end = (div_cnt == LAST_CNT);

  always_comb begin
    nxt_state   = state;
    nxt_bit_cnt = bit_cnt + 5'd1;
    case (state)
      PRE: if (bit_cnt == 5'd31) begin
        nxt_state   = HDR;
        nxt_bit_cnt = '0;
      end
      HDR: if (bit_cnt == 5'd13) begin
        nxt_state   = TA;
        nxt_bit_cnt = '0;
      end
      TA: if (bit_cnt == 5'd1) begin
        nxt_state   = DATA;
        nxt_bit_cnt = '0;
      end
      DATA: if (bit_cnt == 5'd15) begin
        nxt_state   = GAP;
        nxt_bit_cnt = '0;
      end
      GAP: begin
        nxt_state   = IDLE;
        nxt_bit_cnt = '0;
      end
      default: nxt_bit_cnt = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      mdc       <= 1'b0;
      mdio_oe   <= 1'b0;
      mdio_o    <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      cmd_ready <= 1'b0;
      wr_q      <= 1'b0;
      ta_bit    <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state == IDLE) begin
        cmd_ready <= 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          wr_q      <= cmd_write;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          mdio_oe   <= 1'b1;
          // The first bit is driven on the accept edge so its low half starts next cycle
          if (PREAMBLE_EN != 0) begin
            state  <= PRE;
            mdio_o <= 1'b1;
            tx_sr  <= frame;
          end else begin
            state  <= HDR;
            mdio_o <= frame[31];
            tx_sr  <= {frame[30:0], 1'b0};
          end
        end
      end else if (rise) begin
        mdc     <= 1'b1;
        div_cnt <= div_cnt + DIV_W'(1);
        if (state == TA && bit_cnt == 5'd1) begin
          ta_bit <= mdio_i;
        end
        if (state == DATA && !wr_q) begin
          rx_sr <= {rx_sr[13:0], mdio_i};
          if (bit_cnt == 5'd15) begin
            rd_data  <= {rx_sr, mdio_i};
            rd_valid <= 1'b1;
            rd_err   <= (ta_bit != 1'b0);
          end
        end
      end else if (bit_end) begin
        mdc     <= 1'b0;
        div_cnt <= '0;
        state   <= nxt_state;
        bit_cnt <= nxt_bit_cnt;
        case (nxt_state)
          PRE: begin
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b1;
          end
          HDR, TA, DATA: begin
            mdio_o  <= (nxt_state == HDR || wr_q) ? tx_sr[31] : 1'b1;
            mdio_oe <= (nxt_state == HDR || wr_q);
            tx_sr   <= {tx_sr[30:0], 1'b0};
          end
          default: begin
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
            if (nxt_state == IDLE) begin
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        endcase
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// Self-checking bench for phy_mdio_ctrl with CLK_DIV=2 (4-cycle bit period), with and without preamble.
// Expected MDIO bit streams and read results are queued at command time and checked at each MDC rise.
module tb_phy_mdio_ctrl;

  localparam int unsigned CD = 2;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid_np = 1'b0;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        mdio_i_np = 1'b1;

  logic        cmd_ready, rd_valid, rd_err, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data;
  logic        cmd_ready_np, rd_valid_np, rd_err_np, busy_np, mdc_np, mdio_o_np, mdio_oe_np;
  logic [15:0] rd_data_np;

  int checks = 0;
  int passes = 0;

  logic [1:0]  exp_q[$];     // {oe, o} per MDC rise
  logic [1:0]  exp_np_q[$];
  logic [16:0] rd_q[$];      // {err, data}

  bit          phy_present = 1'b1;
  logic        phy_ta = 1'b0;
  logic [15:0] phy_data = '0;

  always #5 sys_clk = ~sys_clk;

  phy_mdio_ctrl #(.CLK_DIV(CD), .PREAMBLE_EN(1)) dut (
    .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  phy_mdio_ctrl #(.CLK_DIV(CD), .PREAMBLE_EN(0)) dut_np (
    .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid_np), .cmd_ready(cmd_ready_np),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rd_data(rd_data_np), .rd_valid(rd_valid_np), .rd_err(rd_err_np),
    .busy(busy_np), .mdc(mdc_np), .mdio_o(mdio_o_np), .mdio_oe(mdio_oe_np), .mdio_i(mdio_i_np)
  );

  // PHY answer for MDC rise k of a frame: 0 on the second TA bit, then phy_data MSB-first
  function automatic logic phy_bit(input int k);
    if (!phy_present) return 1'b1;
    if (k == 47) return phy_ta;
    if (k >= 48 && k <= 63) return phy_data[63 - k];
    return 1'b1;
  endfunction

  initial begin : mon_main
    logic       mdc_prev;
    int         rise_idx;
    logic [1:0] e;
    logic [16:0] r;
    mdc_prev = 1'b0;
    rise_idx = 0;
    forever begin
      @(negedge sys_clk);
      if (!busy) begin
        rise_idx = 0;
      end else if (mdc && !mdc_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL bitstream: unexpected mdc rise %0d, oe/o=%b%b required no rise",
                   rise_idx, mdio_oe, mdio_o);
        end else begin
          e = exp_q.pop_front();
          if (mdio_oe === e[1] && (!e[1] || mdio_o === e[0])) passes++;
          else $display("FAIL bitstream rise %0d: oe/o=%b%b required %b%b",
                        rise_idx, mdio_oe, mdio_o, e[1], e[0]);
        end
        rise_idx++;
      end
      mdc_prev = mdc;
      mdio_i = phy_bit(rise_idx);
      if (rd_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          $display("FAIL rd_result: unexpected rd_valid, data=%h err=%b required none", rd_data, rd_err);
        end else begin
          r = rd_q.pop_front();
          if (rd_data === r[15:0] && rd_err === r[16]) passes++;
          else $display("FAIL rd_result: data=%h err=%b required data=%h err=%b",
                        rd_data, rd_err, r[15:0], r[16]);
        end
      end
    end
  end

  initial begin : mon_np
    logic       mdc_prev;
    logic [1:0] e;
    mdc_prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (mdc_np && !mdc_prev) begin
        checks++;
        if (exp_np_q.size() == 0) begin
          $display("FAIL np_bitstream: unexpected mdc rise, oe/o=%b%b required no rise",
                   mdio_oe_np, mdio_o_np);
        end else begin
          e = exp_np_q.pop_front();
          if (mdio_oe_np === e[1] && (!e[1] || mdio_o_np === e[0])) passes++;
          else $display("FAIL np_bitstream: oe/o=%b%b required %b%b",
                        mdio_oe_np, mdio_o_np, e[1], e[0]);
        end
      end
      mdc_prev = mdc_np;
      if (rd_valid_np) begin
        checks++;
        $display("FAIL np_rd_valid: rd_valid=1 required 0");
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "time limit");
  end

  task automatic push_frame(input bit np, input bit wr, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd);
    logic [13:0] hdr;
    logic [1:0]  q[$];
    hdr = {2'b01, (wr ? 2'b01 : 2'b10), pa, ra};
    if (!np) for (int i = 0; i < 32; i++) q.push_back(2'b11);
    for (int i = 13; i >= 0; i--) q.push_back({1'b1, hdr[i]});
    if (wr) begin
      q.push_back(2'b11);
      q.push_back(2'b10);
      for (int i = 15; i >= 0; i--) q.push_back({1'b1, wd[i]});
    end else begin
      for (int i = 0; i < 18; i++) q.push_back(2'b01);
    end
    q.push_back(2'b01);
    foreach (q[i]) begin
      if (np) exp_np_q.push_back(q[i]);
      else exp_q.push_back(q[i]);
    end
  endtask

  // Drives a command and returns just after its accepting edge (ok=0 if never accepted)
  task automatic send_cmd(input bit np, input bit wr, input logic [4:0] pa,
                          input logic [4:0] ra, input logic [15:0] wd, output bit ok);
    @(negedge sys_clk);
    cmd_write = wr;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata = wd;
    if (np) cmd_valid_np = 1'b1;
    else cmd_valid = 1'b1;
    push_frame(np, wr, pa, ra, wd);
    if (!wr && !np) rd_q.push_back(phy_present ? {phy_ta, phy_data} : {1'b1, 16'hFFFF});
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (np ? cmd_ready_np : cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (ok) @(posedge sys_clk);
  endtask

  // Observes cycles after an accept; idle_cyc is the first cycle with cmd_ready high (-1 on timeout)
  task automatic wait_frame(input bit np, input bit hold, output int busy_cyc,
                            output int rdv_cyc, output int rdv_cnt, output int idle_cyc);
    busy_cyc = 0;
    rdv_cyc = -1;
    rdv_cnt = 0;
    idle_cyc = -1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge sys_clk);
      if (c == 1 && !hold) begin
        cmd_valid = 1'b0;
        cmd_valid_np = 1'b0;
      end
      if (np ? busy_np : busy) busy_cyc++;
      if (np ? rd_valid_np : rd_valid) begin
        rdv_cnt++;
        rdv_cyc = c;
      end
      if (np ? cmd_ready_np : cmd_ready) begin
        idle_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: %b required 0", cmd_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: %b required 0", busy); else passes++;
    checks++; if (mdc !== 1'b0) $display("FAIL reset_mdc: %b required 0", mdc); else passes++;
    checks++; if (mdio_oe !== 1'b0) $display("FAIL reset_mdio_oe: %b required 0", mdio_oe); else passes++;
    checks++; if (mdio_o !== 1'b1) $display("FAIL reset_mdio_o: %b required 1", mdio_o); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: %b required 0", rd_valid); else passes++;
    checks++; if (rd_data !== 16'h0000) $display("FAIL reset_rd_data: %h required 0000", rd_data); else passes++;
    checks++; if (rd_err !== 1'b0) $display("FAIL reset_rd_err: %b required 0", rd_err); else passes++;
    rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: %b required 1", cmd_ready); else passes++;
    checks++; if (cmd_ready_np !== 1'b1) $display("FAIL reset_release_ready_np: %b required 1", cmd_ready_np); else passes++;
  endtask

  task automatic test_read();
    bit ok;
    int bc, rc, rn, ic;
    phy_present = 1'b1;
    phy_ta = 1'b0;
    phy_data = 16'h782D;
    send_cmd(1'b0, 1'b0, 5'd1, 5'd1, 16'h0000, ok);
    wait_frame(1'b0, 1'b0, bc, rc, rn, ic);
    checks++; if (!ok) $display("FAIL read_accept: not accepted required accept"); else passes++;
    checks++; if (rn != 1) $display("FAIL read_rd_valid_count: %0d required 1", rn); else passes++;
    checks++; if (rc != 255) $display("FAIL read_rd_valid_cycle: %0d required 255", rc); else passes++;
    checks++; if (rd_data !== 16'h782D) $display("FAIL read_rd_data: %h required 782d", rd_data); else passes++;
    checks++; if (rd_err !== 1'b0) $display("FAIL read_rd_err: %b required 0", rd_err); else passes++;
    checks++; if (bc != 260) $display("FAIL read_busy_cycles: %0d required 260", bc); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL read_stream_left: %0d rises required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_write();
    bit ok;
    int bc, rc, rn, ic;
    send_cmd(1'b0, 1'b1, 5'd1, 5'd0, 16'h3100, ok);
    wait_frame(1'b0, 1'b0, bc, rc, rn, ic);
    checks++; if (!ok) $display("FAIL write_accept: not accepted required accept"); else passes++;
    checks++; if (bc != 260) $display("FAIL write_busy_cycles: %0d required 260", bc); else passes++;
    checks++; if (ic != 261) $display("FAIL write_ready_cycle: %0d required 261", ic); else passes++;
    checks++; if (rn != 0) $display("FAIL write_rd_valid: %0d pulses required 0", rn); else passes++;
    checks++; if (rd_data !== 16'h782D) $display("FAIL write_rd_data_hold: %h required 782d", rd_data); else passes++;
    checks++; if (rd_err !== 1'b0) $display("FAIL write_rd_err_hold: %b required 0", rd_err); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL write_stream_left: %0d rises required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_no_phy();
    bit ok;
    int bc, rc, rn, ic;
    phy_present = 1'b0;
    send_cmd(1'b0, 1'b0, 5'd2, 5'd3, 16'h0000, ok);
    wait_frame(1'b0, 1'b0, bc, rc, rn, ic);
    checks++; if (rn != 1) $display("FAIL nophy_rd_valid_count: %0d required 1", rn); else passes++;
    checks++; if (rd_data !== 16'hFFFF) $display("FAIL nophy_rd_data: %h required ffff", rd_data); else passes++;
    checks++; if (rd_err !== 1'b1) $display("FAIL nophy_rd_err: %b required 1", rd_err); else passes++;
    phy_present = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bc, rc, rn, ic;
    phy_ta = 1'b0;
    phy_data = 16'h1234;
    send_cmd(1'b0, 1'b1, 5'd3, 5'd4, 16'hA5A5, ok);
    // Fields for the second command change one cycle into the first frame, valid stays high
    @(negedge sys_clk);
    cmd_write = 1'b0;
    cmd_phy_addr = 5'd5;
    cmd_reg_addr = 5'd6;
    cmd_wdata = 16'h0F0F;
    push_frame(1'b0, 1'b0, 5'd5, 5'd6, 16'h0F0F);
    rd_q.push_back({phy_ta, phy_data});
    wait_frame(1'b0, 1'b1, bc, rc, rn, ic);
    checks++; if (ic + 1 != 261) $display("FAIL b2b_accept_interval: %0d required 261", ic + 1); else passes++;
    checks++; if (bc + 1 != 260) $display("FAIL b2b_ready_low_span: %0d required 260", bc + 1); else passes++;
    checks++; if (rn != 0) $display("FAIL b2b_first_rd_valid: %0d required 0", rn); else passes++;
    @(posedge sys_clk);
    wait_frame(1'b0, 1'b0, bc, rc, rn, ic);
    checks++; if (rn != 1) $display("FAIL b2b_second_rd_valid: %0d required 1", rn); else passes++;
    checks++; if (rd_data !== 16'h1234) $display("FAIL b2b_rd_data: %h required 1234", rd_data); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL b2b_stream_left: %0d rises required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int rn;
    phy_data = 16'hBEEF;
    send_cmd(1'b0, 1'b0, 5'd1, 5'd2, 16'h0000, ok);
    for (int c = 1; c <= 161; c++) begin
      @(negedge sys_clk);
      if (c == 1) cmd_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge sys_clk);
    exp_q.delete();
    rd_q.delete();
    checks++; if (mdc !== 1'b0) $display("FAIL abort_mdc: %b required 0", mdc); else passes++;
    checks++; if (mdio_oe !== 1'b0) $display("FAIL abort_mdio_oe: %b required 0", mdio_oe); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: %b required 0", busy); else passes++;
    checks++; if (rd_data !== 16'h0000) $display("FAIL abort_rd_data: %h required 0000", rd_data); else passes++;
    rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready: %b required 1", cmd_ready); else passes++;
    rn = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge sys_clk);
      if (rd_valid) rn++;
    end
    checks++; if (rn != 0) $display("FAIL abort_rd_valid: %0d pulses required 0", rn); else passes++;
  endtask

  task automatic test_no_preamble();
    bit ok;
    int bc, rc, rn, ic;
    send_cmd(1'b1, 1'b1, 5'd7, 5'd9, 16'hC0DE, ok);
    wait_frame(1'b1, 1'b0, bc, rc, rn, ic);
    checks++; if (!ok) $display("FAIL np_accept: not accepted required accept"); else passes++;
    checks++; if (bc != 132) $display("FAIL np_busy_cycles: %0d required 132", bc); else passes++;
    checks++; if (ic != 133) $display("FAIL np_ready_cycle: %0d required 133", ic); else passes++;
    checks++; if (rn != 0) $display("FAIL np_rd_valid: %0d required 0", rn); else passes++;
    checks++; if (exp_np_q.size() != 0) $display("FAIL np_stream_left: %0d rises required 0", exp_np_q.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_no_phy();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_preamble();
    repeat (4) @(negedge sys_clk);
    checks++; if (rd_q.size() != 0) $display("FAIL rd_results_left: %0d required 0", rd_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
